kalman_result_fix: RTL and testbench
====================================

Name: kalman_result_fix

Overview:
- Downstream stage of the Kalman filter core.
- Captures the updated state estimate X (IEEE-754 single) on the filter's End_flag pulse and converts it to a 9-bit unsigned pixel-domain integer, matching the width of the sample source.
- Conversion is multi-cycle: round half-up, then saturate to 0..511.
- The result is held behind a valid/ready handshake for the display/compare path.
- Counts estimates that arrive while the converter is busy, so the integrator can size the pipeline.

Parameters:
- DROP_W, 8, width of the saturating dropped-estimate counter.
- MAX_VAL, 511, saturation ceiling for the output code (must fit in 9 bits).

Ports:
- clk_50M  input  1  system clock, all logic on rising edge
- Rst  input  1  asynchronous, active-high reset
- X  input  32  IEEE-754 single-precision state estimate from the filter update stage
- End_flag  input  1  one-cycle pulse, X valid this cycle
- o_data  output  9  converted unsigned integer result
- o_valid  output  1  o_data/o_sat valid; held until accepted
- o_ready  input  1  consumer accepts when o_valid && o_ready
- o_sat  output  1  result was clamped (negative, NaN/Inf, or >MAX_VAL after rounding)
- busy  output  1  high whenever state != IDLE
- drop_cnt  output  DROP_W  number of End_flag pulses ignored while busy (saturating)

Behaviour:
- Interface: one clock, clk_50M. Rst is asynchronous and active-high.
- Reset (asynchronous, any time, including mid-conversion):
  - state = IDLE.
  - o_data = 0, o_valid = 0, o_sat = 0, busy = 0, drop_cnt = 0.
  - Internal shift register, guard bit and counters cleared.
- FSM states: IDLE, DECODE, SHIFT, ROUND, OUT.
- IDLE:
  - On End_flag, latch X at edge T0 and go to DECODE.
  - A latched X stays frozen until return to IDLE.
- DECODE (edge T1): fields s = X[31], e = X[30:23], m = {1, X[22:0]} (24 bits), E = e - 127.
  - Special cases go directly to ROUND with a forced result and guard = 0:
    - e == 255 (Inf/NaN, either sign): result MAX_VAL, sat = 1.
    - s == 1 and value nonzero (e != 0): result 0, sat = 1.
    - e == 0 (zero or denormal, either sign): result 0, sat = 0.
    - E >= 9: result MAX_VAL, sat = 1.
    - E <= -2: result 0, sat = 0.
  - Otherwise (-1 <= E <= 8): load m into the shift register, set shift count n = 23 - E (range 15..24), go to SHIFT.
- SHIFT:
  - Each edge shifts the register right by 1 bit and loads guard with the bit shifted out.
  - Decrements n; when n reaches 0, go to ROUND.
  - Exactly n SHIFT edges (T2..T1+n).
- ROUND (one edge):
  - result = shifted value + guard (round half-up).
  - If result > MAX_VAL, clamp to MAX_VAL and set sat = 1.
  - Load o_data/o_sat, assert o_valid, go to OUT.
- Latency, capture edge T0 to o_valid high:
  - 2 + n edges for the normal path. Examples: 1.0 gives 25 edges; E = 8 gives 17 edges.
  - 2 edges for special cases.
- OUT:
  - o_data and o_sat are stable while o_valid = 1.
  - On an edge with o_ready = 1: o_valid goes to 0 and state goes to IDLE. o_data and o_sat keep their last value.
  - o_ready has no effect outside OUT.
- busy = (state != IDLE), registered with the state.
- End_flag handling outside IDLE:
  - End_flag is ignored, including in the acceptance cycle of OUT.
  - drop_cnt increments by 1 per ignored pulse and saturates at 2^DROP_W - 1 (no wrap).
  - End_flag in IDLE never increments drop_cnt.
- End_flag held high for multiple cycles counts as:
  - one capture in IDLE;
  - one drop for each subsequent busy cycle.

Test Plan:
1. Reset check: assert Rst mid-SHIFT, then release. All outputs are zero and state is IDLE; a new End_flag with X=0x3F800000 gives o_data=1, o_sat=0, o_valid rising 25 edges after capture.
2. Rounding and the 0.5 boundary:
   - 0x40200000 (2.5) gives 3.
   - 0x3F000000 (0.5) gives 1 (E=-1, n=24).
   - 0x3E800000 (0.25) gives 0 with o_sat=0, valid after 2 edges.
3. Upper bound:
   - 0x43FF8000 (511.0) gives 511, o_sat=0, latency 17.
   - 0x43FFC000 (511.5) gives 511, o_sat=1.
   - 0x44000000 (512.0) gives 511, o_sat=1, latency 2.
4. Specials:
   - 0xBF800000 (-1.0) gives 0, o_sat=1.
   - 0x80000000 (-0) gives 0, o_sat=0.
   - 0x7FC00000 (NaN) gives 511, o_sat=1.
   - 0x7F800000 (+Inf) gives 511, o_sat=1.
5. Backpressure: hold o_ready=0 for 40 cycles after o_valid. o_data and o_valid stay stable; End_flag pulsed 3 times during the hold gives drop_cnt=3. Raising o_ready returns the block to IDLE and busy drops one edge later.
6. Counter saturation: 300 End_flag pulses while busy give drop_cnt=255, with no wrap.

Source files
------------

// File: rtl/kalman_result_fix_if.sv
// Estimate-in / pixel-code-out bus of the Kalman result fixer.
// The master side drives the estimate and accepts the code, and the slave side is the converter.
interface kalman_result_fix_if;
  logic [31:0] X;
  logic        End_flag;
  logic [8:0]  o_data;
  logic        o_valid;
  logic        o_ready;
  logic        o_sat;

  modport master (
    output X, End_flag, o_ready,
    input  o_data, o_valid, o_sat
  );

  modport slave (
    input  X, End_flag, o_ready,
    output o_data, o_valid, o_sat
  );
endinterface

// File: rtl/kalman_result_fix.sv
// Converts the Kalman state estimate X (IEEE-754 single) to a rounded, saturated 9-bit pixel code.
// The result is presented on a valid/ready handshake, and estimates that arrive while the block is busy are counted as drops.
module kalman_result_fix #(
  parameter int DROP_W  = 8,
  parameter int MAX_VAL = 511
) (
  input  logic              clk_50M,
  input  logic              Rst,
  kalman_result_fix_if.slave bus,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  localparam logic [8:0]        MAX_CODE = 9'(MAX_VAL);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [2:0]  state;
  logic [31:0] x_lat;
  logic [23:0] shift_reg;
  logic        guard;
  logic [4:0]  shift_cnt;
  logic        sat_pend;

  logic [7:0]  exp_f;
  logic [24:0] rounded;
  logic        over_max;

  assign exp_f    = x_lat[30:23];
  assign rounded  = {1'b0, shift_reg} + {24'd0, guard};
  assign over_max = rounded > {16'd0, MAX_CODE};
  assign busy     = (state != IDLE);

  // Special encodings are decoded straight to a forced code held in shift_reg, so ROUND treats both paths alike.
  // In-range values are shifted right by 150 - e, which is between 15 and 24 bit positions.
  always_ff @(posedge clk_50M or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      x_lat       <= '0;
      shift_reg   <= '0;
      guard       <= 1'b0;
      shift_cnt   <= '0;
      sat_pend    <= 1'b0;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.End_flag) begin
            x_lat <= bus.X;
            state <= DECODE;
          end
        end
        DECODE: begin
          guard    <= 1'b0;
          sat_pend <= 1'b0;
          state    <= ROUND;
          if (exp_f == 8'hFF) begin
            shift_reg <= {15'd0, MAX_CODE};
            sat_pend  <= 1'b1;
          end else if (x_lat[31] && (exp_f != 8'd0)) begin
            shift_reg <= '0;
            sat_pend  <= 1'b1;
          end else if (exp_f == 8'd0) begin
            shift_reg <= '0;
          end else if (exp_f >= 8'd136) begin
            shift_reg <= {15'd0, MAX_CODE};
            sat_pend  <= 1'b1;
          end else if (exp_f <= 8'd125) begin
            shift_reg <= '0;
          end else begin
            shift_reg <= {1'b1, x_lat[22:0]};
            shift_cnt <= 5'(8'd150 - exp_f);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg >> 1;
          guard     <= shift_reg[0];
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (over_max) begin
            bus.o_data <= MAX_CODE;
            bus.o_sat  <= 1'b1;
          end else begin
            bus.o_data <= rounded[8:0];
            bus.o_sat  <= sat_pend;
          end
          bus.o_valid <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.o_ready) begin
            bus.o_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any End_flag seen outside IDLE is lost, including in the cycle the result is accepted.
  always_ff @(posedge clk_50M or posedge Rst) begin
    if (Rst) begin
      drop_cnt <= '0;
    end else if (bus.End_flag && (state != IDLE) && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kalman_result_fix.sv
// Scoreboard bench for kalman_result_fix.
// Directed estimates push their hand-computed code, saturation flag and latency, and a monitor checks each rising o_valid against them.
module tb_kalman_result_fix;

  logic       clk_50M = 1'b0;
  logic       Rst;
  logic       busy;
  logic [7:0] drop_cnt;

  kalman_result_fix_if bus_if ();

  kalman_result_fix #(.DROP_W(8), .MAX_VAL(511)) dut (
    .clk_50M  (clk_50M),
    .Rst      (Rst),
    .bus      (bus_if.slave),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] data;
    logic       sat;
    int         lat;
    int         cap;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // The monitor compares once per transaction, on the first cycle that o_valid is seen high.
  always @(negedge clk_50M) begin
    exp_t e;
    if (Rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus_if.o_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got o_data=%0d with no expected entry", bus_if.o_data);
        end else begin
          e = sb_q.pop_front();
          checkOutput({e.name, "_data"}, 32'(bus_if.o_data), 32'(e.data));
          checkOutput({e.name, "_sat"}, 32'(bus_if.o_sat), 32'(e.sat));
          checkOutput({e.name, "_latency"}, 32'(cyc - e.cap), 32'(e.lat));
        end
      end
      prev_valid = bus_if.o_valid;
    end
  end

  // The capture edge is the next posedge, and the monitor's negedge after edge cap+lat sees cyc equal to cap+lat.
  task automatic applyStimulus(input logic [31:0] x, input logic [8:0] d, input logic s,
                               input int lat, input string name);
    exp_t e;
    @(negedge clk_50M);
    bus_if.X        = x;
    bus_if.End_flag = 1'b1;
    e.data = d; e.sat = s; e.lat = lat; e.cap = cyc + 1; e.name = name;
    sb_q.push_back(e);
    @(negedge clk_50M);
    bus_if.End_flag = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clk_50M);
    while ((busy || bus_if.o_valid) && n < 200) begin
      @(negedge clk_50M);
      n++;
    end
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic runVec(input logic [31:0] x, input logic [8:0] d, input logic s,
                        input int lat, input string name);
    applyStimulus(x, d, s, lat, name);
    waitIdle(name);
  endtask

  task automatic dropPulse();
    @(negedge clk_50M);
    bus_if.End_flag = 1'b1;
    @(negedge clk_50M);
    bus_if.End_flag = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic stable;
    int   n;
    bus_if.X        = '0;
    bus_if.End_flag = 1'b0;
    bus_if.o_ready  = 1'b1;
    Rst             = 1'b1;
    repeat (3) @(negedge clk_50M);
    checkOutput("rst_o_data", 32'(bus_if.o_data), 32'd0);
    checkOutput("rst_o_valid", 32'(bus_if.o_valid), 32'd0);
    checkOutput("rst_o_sat", 32'(bus_if.o_sat), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    Rst = 1'b0;

    // Reset asserted part-way through SHIFT, after two drops have been counted.
    @(negedge clk_50M);
    bus_if.X        = 32'h3F800000;
    bus_if.End_flag = 1'b1;
    @(negedge clk_50M);
    bus_if.End_flag = 1'b0;
    dropPulse();
    dropPulse();
    checkOutput("pre_rst_drop_cnt", 32'(drop_cnt), 32'd2);
    repeat (5) @(negedge clk_50M);
    #2 Rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("midrst_o_valid", 32'(bus_if.o_valid), 32'd0);
    checkOutput("midrst_o_data", 32'(bus_if.o_data), 32'd0);
    checkOutput("midrst_o_sat", 32'(bus_if.o_sat), 32'd0);
    @(negedge clk_50M);
    Rst = 1'b0;
    runVec(32'h3F800000, 9'd1, 1'b0, 25, "one");

    runVec(32'h40200000, 9'd3,   1'b0, 24, "two_half");
    runVec(32'h3F000000, 9'd1,   1'b0, 26, "half");
    runVec(32'h3E800000, 9'd0,   1'b0, 2,  "quarter");
    runVec(32'h43FF8000, 9'd511, 1'b0, 17, "v511");
    runVec(32'h43FFC000, 9'd511, 1'b1, 17, "v511_5");
    runVec(32'h44000000, 9'd511, 1'b1, 2,  "v512");
    runVec(32'hBF800000, 9'd0,   1'b1, 2,  "neg_one");
    runVec(32'h80000000, 9'd0,   1'b0, 2,  "neg_zero");
    runVec(32'h7FC00000, 9'd511, 1'b1, 2,  "nan");
    runVec(32'h7F800000, 9'd511, 1'b1, 2,  "pos_inf");

    // Backpressure: the result is held for 40 cycles while three estimates are dropped.
    bus_if.o_ready = 1'b0;
    applyStimulus(32'h3F800000, 9'd1, 1'b0, 25, "bp");
    n = 0;
    while (!bus_if.o_valid && n < 60) begin
      @(negedge clk_50M);
      n++;
    end
    checkOutput("bp_valid_seen", 32'(bus_if.o_valid), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50M);
      bus_if.End_flag = (i == 5 || i == 15 || i == 25);
      if (bus_if.o_valid !== 1'b1 || bus_if.o_data !== 9'd1) stable = 1'b0;
    end
    bus_if.End_flag = 1'b0;
    checkOutput("bp_hold_stable", 32'(stable), 32'd1);
    checkOutput("bp_drop_cnt", 32'(drop_cnt), 32'd3);
    checkOutput("bp_busy_held", 32'(busy), 32'd1);
    bus_if.o_ready = 1'b1;
    @(negedge clk_50M);
    checkOutput("bp_busy_released", 32'(busy), 32'd0);
    checkOutput("bp_valid_released", 32'(bus_if.o_valid), 32'd0);
    checkOutput("bp_data_kept", 32'(bus_if.o_data), 32'd1);
    checkOutput("bp_sat_kept", 32'(bus_if.o_sat), 32'd0);

    // 300 further busy-cycle drops take the counter from 3 to its 255 ceiling.
    bus_if.o_ready = 1'b0;
    applyStimulus(32'h40200000, 9'd3, 1'b0, 24, "satrun");
    @(negedge clk_50M);
    bus_if.End_flag = 1'b1;
    repeat (300) @(negedge clk_50M);
    bus_if.End_flag = 1'b0;
    checkOutput("drop_cnt_saturated", 32'(drop_cnt), 32'd255);
    bus_if.o_ready = 1'b1;
    waitIdle("satrun");
    checkOutput("drop_cnt_no_wrap", 32'(drop_cnt), 32'd255);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
